serial_add_scheduler: RTL and testbench
=======================================

SERIAL_ADD_SCHEDULER -- requirements
Module: serial_add_scheduler

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand/sum width in bits; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, rising-edge system clock.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, requester n has an operand pair pending.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, operand pair of requester n accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, W each, operands of requester n.
REQ-007 SHALL have port res_valid, output, 1, result available.
REQ-008 SHALL have port res_ready, input, 1, consumer accepts result.
REQ-009 SHALL have port res_sum, output, W, sum modulo 2^W.
REQ-010 SHALL have port res_cout, output, 1, carry out of bit W-1.
REQ-011 SHALL have port res_id, output, 1, index of the requester that owns the result.

Function
REQ-012 SHALL contain one shared bit-serial adder: one carry flop; sum bit = a^b^c; next carry = majority(a,b,c).
REQ-013 SHALL implement the adder with logic operations only; no "+" operator anywhere in the block.
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 IDLE: SHALL grant at most one requester per cycle; reqN_ready = IDLE && grant==N && reqN_valid.
REQ-016 Arbitration SHALL be round-robin:
- only one valid requester: it is granted;
- both valid: the requester not granted last time is granted;
- after reset: req0 has priority.
REQ-017 Acceptance SHALL occur on a clock edge where valid && ready is true.
- On that edge: capture a and b into shift registers, clear carry, clear bit counter, record res_id.
- Next state: SHIFT.
REQ-018 SHIFT: SHALL process one bit per clock, LSB first.
- Each edge: shift the sum bit into the MSB of the sum register, shift the operand registers right, update carry, increment counter.
REQ-019 After exactly W SHIFT edges, SHALL enter DONE.
- res_sum holds the full sum; res_cout holds the final carry.
- res_valid goes high on that edge.
REQ-020 DONE: res_valid, res_sum, res_cout and res_id SHALL stay stable until the edge where res_ready is sampled high; that edge SHALL move the FSM to IDLE.
REQ-021 res_valid SHALL be low in IDLE and SHIFT; res_sum, res_cout and res_id SHALL hold their last value outside DONE.
REQ-022 Latency: res_valid SHALL rise W edges after the acceptance edge; minimum issue interval is W+2 cycles; no IDLE bypass.
REQ-023 reqN_ready SHALL be low in SHIFT and DONE; requesters hold valid and data until accepted; input changes during SHIFT/DONE SHALL NOT affect the result in flight.
REQ-024 res_ready high in the same cycle res_valid first rises SHALL complete the transfer on the next edge.
REQ-025 The last-grant pointer SHALL update only on an acceptance edge.
REQ-026 reqN_ready SHALL depend combinationally on reqN_valid; no output SHALL depend combinationally on res_ready.

Reset
REQ-027 rst low SHALL immediately, without waiting for clk, force:
- state IDLE;
- carry, counter, shift registers, res_sum, res_cout and res_id to 0;
- res_valid 0;
- last-grant pointer so that req0 wins next.
REQ-028 reqN_ready SHALL be 0 while rst is low.
REQ-029 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no result is produced after release.
REQ-030 The first acceptance SHALL be possible on the first clk edge after rst deasserts.

Verification
REQ-031 W=8: req0 a=0x92, b=0x54, res_ready=1 -> after 8 SHIFT edges, res_valid=1, res_sum=0xE6, res_cout=0, res_id=0.
REQ-032 W=16: req1 a=0x8192, b=0x2154 -> res_sum=0xA2E6, res_cout=0, res_id=1.
REQ-033 W=8: a=0xFF, b=0x01 -> res_sum=0x00, res_cout=1.
REQ-034 W=8: a=0xFF, b=0xFF -> res_sum=0xFE, res_cout=1.
REQ-035 Both requesters continuously valid for 4 operations -> grants/res_id sequence 0,1,0,1; each req asserts ready exactly once per its grant.
REQ-036 Backpressure: hold res_ready=0 for 5 cycles in DONE -> outputs stable.
- res_ready=1 -> IDLE next edge.
- New acceptance no earlier than the following edge.
REQ-037 Reset mid-operation: assert rst asynchronously (between edges) after 3 SHIFT edges -> res_valid stays 0.
- Outputs read 0.
- After release, req0 request 0x01+0x01 -> res_sum=0x02, res_id=0.

Source files
------------

// File: rtl/serial_add_scheduler.sv
// Two-requester round-robin front end sharing one bit-serial adder (one sum bit per clock, LSB first).
// Latency: result valid W edges after acceptance; result held in DONE until res_ready, requesters stall meanwhile.
module serial_add_scheduler #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [W-1:0] res_sum,
   output logic         res_cout,
   output logic         res_id
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   logic [1:0]   state;
   logic [W-1:0] a_sr;
   logic [W-1:0] b_sr;
   logic [W-1:0] sum_sr;
   logic [W-2:0] cnt;
   logic         carry;
   logic         own_id;
   logic         last_grant;
   logic         grant;
   logic         accept;
   logic         sbit;
   logic         cnext;
   logic [W-1:0] sum_next;

   // Contention alternates; a lone requester always wins.
   always_comb begin
      grant = req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant;
      end
   end

   assign req0_ready = rst && (state == IDLE) && !grant && req0_valid;
   assign req1_ready = rst && (state == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready | req1_ready;

   assign sbit     = a_sr[0] ^ b_sr[0] ^ carry;
   assign cnext    = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
   assign sum_next = {sbit, sum_sr[W-1:1]};

   assign res_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         sum_sr     <= '0;
         cnt        <= '0;
         carry      <= 1'b0;
         own_id     <= 1'b0;
         last_grant <= 1'b1;
         res_sum    <= '0;
         res_cout   <= 1'b0;
         res_id     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_sr       <= grant ? req1_a : req0_a;
                  b_sr       <= grant ? req1_b : req0_b;
                  sum_sr     <= '0;
                  carry      <= 1'b0;
                  cnt        <= '0;
                  own_id     <= grant;
                  last_grant <= grant;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               sum_sr <= sum_next;
               carry  <= cnext;
               // Thermometer counter: one more 1 shifted in per bit processed.
               cnt    <= ~(~cnt << 1);
               if (cnt[W-2]) begin
                  res_sum  <= sum_next;
                  res_cout <= cnext;
                  res_id   <= own_id;
                  state    <= DONE;
               end
            end
            DONE: begin
               if (res_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Directed bench for serial_add_scheduler: W=8 instance for most steps, W=16 instance for the wide sum.
module tb_serial_add_scheduler;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       r0v = 0, r1v = 0, rrdy = 1;
   logic [7:0] r0a = 0, r0b = 0, r1a = 0, r1b = 0;
   logic       r0r, r1r, rv, rc, rid;
   logic [7:0] rs;

   logic        w0v = 0, w1v = 0, wrdy = 1;
   logic [15:0] w0a = 0, w0b = 0, w1a = 0, w1b = 0;
   logic        w0r, w1r, wv, wc, wid;
   logic [15:0] ws;

   int tests = 0;
   int failed = 0;

   serial_add_scheduler #(.W(8)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
      .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
      .res_valid(rv), .res_ready(rrdy), .res_sum(rs), .res_cout(rc), .res_id(rid)
   );

   serial_add_scheduler #(.W(16)) dut16 (
      .clk(clk), .rst(rst),
      .req0_valid(w0v), .req0_ready(w0r), .req0_a(w0a), .req0_b(w0b),
      .req1_valid(w1v), .req1_ready(w1r), .req1_a(w1a), .req1_b(w1b),
      .res_valid(wv), .res_ready(wrdy), .res_sum(ws), .res_cout(wc), .res_id(wid)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic op8(input logic id, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] es, input logic ec, input string tag);
      int n;
      @(negedge clk);
      if (id) begin r1v = 1; r1a = a; r1b = b; end
      else    begin r0v = 1; r0a = a; r0b = b; end
      #1;
      chk({tag, "_rdy"}, {31'd0, id ? r1r : r0r}, 1);
      @(negedge clk);
      r0v = 0; r1v = 0;
      r0a = ~a; r0b = ~b; r1a = ~a; r1b = ~b;
      #1;
      chk({tag, "_rdy_low"}, {31'd0, r0r | r1r}, 0);
      n = 0;
      while (!rv && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, 8);
      chk({tag, "_sum"}, {24'd0, rs}, {24'd0, es});
      chk({tag, "_cout"}, {31'd0, rc}, {31'd0, ec});
      chk({tag, "_id"}, {31'd0, rid}, {31'd0, id});
      @(negedge clk);
      chk({tag, "_idle"}, {31'd0, rv}, 0);
   endtask

   initial begin
      int n;
      int c0, c1, both, nres;
      logic [3:0] grants;
      logic [3:0] ids;
      logic [31:0] sums;

      // Reset state, with valid asserted to confirm ready is masked.
      r0v = 1;
      #3;
      chk("rst_valid", {31'd0, rv}, 0);
      chk("rst_outs", {22'd0, rid, rc, rs}, 0);
      chk("rst_ready", {30'd0, r0r, r1r}, 0);
      r0v = 0;

      // Round robin with both requesters continuously valid.
      @(negedge clk);
      rst = 1;
      r0v = 1; r0a = 8'h10; r0b = 8'h20;
      r1v = 1; r1a = 8'h05; r1b = 8'h07;
      c0 = 0; c1 = 0; both = 0; nres = 0; grants = 0; ids = 0; sums = 0;
      for (int i = 0; i < 40; i++) begin
         #1;
         if (r0r && r1r) both++;
         if (r0r) begin grants[c0 + c1] = 1'b0; c0++; end
         else if (r1r) begin grants[c0 + c1] = 1'b1; c1++; end
         if (rv && nres < 4) begin
            ids[nres] = rid;
            sums[nres*8 +: 8] = rs;
            nres++;
         end
         @(negedge clk);
      end
      r0v = 0; r1v = 0;
      chk("rr_both_ready", both, 0);
      chk("rr_ready0_cnt", c0, 2);
      chk("rr_ready1_cnt", c1, 2);
      chk("rr_grants", {28'd0, grants}, 32'b1010);
      chk("rr_nres", nres, 4);
      chk("rr_ids", {28'd0, ids}, 32'b1010);
      chk("rr_sums", sums, 32'h0C300C30);

      op8(1'b0, 8'h92, 8'h54, 8'hE6, 1'b0, "add_92_54");
      op8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, "add_ff_01");
      op8(1'b1, 8'hFF, 8'hFF, 8'hFE, 1'b1, "add_ff_ff");

      // Wide instance, requester 1.
      @(negedge clk);
      w1v = 1; w1a = 16'h8192; w1b = 16'h2154;
      #1;
      chk("w16_rdy", {31'd0, w1r}, 1);
      @(negedge clk);
      w1v = 0; w1a = 16'hFFFF;
      n = 0;
      while (!wv && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("w16_lat", n, 16);
      chk("w16_sum", {16'd0, ws}, 32'h0000A2E6);
      chk("w16_cout_id", {30'd0, wc, wid}, 32'b01);

      // Backpressure in DONE.
      rrdy = 0;
      @(negedge clk);
      r0v = 1; r0a = 8'h92; r0b = 8'h54;
      @(negedge clk);
      r0v = 0; r0a = 8'h00;
      n = 0;
      while (!rv && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_lat", n, 8);
      r1v = 1; r1a = 8'h10; r1b = 8'h01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_hold", {20'd0, rv, rc, rid, r1r, rs}, {20'd0, 4'b1000, 8'hE6});
      end
      rrdy = 1;
      #1;
      chk("bp_rdy_in_done", {31'd0, r1r}, 0);
      @(negedge clk);
      chk("bp_idle_valid", {31'd0, rv}, 0);
      chk("bp_idle_ready", {31'd0, r1r}, 1);
      @(negedge clk);
      r1v = 0;
      #1;
      chk("bp_shift_hold", {22'd0, rid, rc, rs}, {22'd0, 2'b00, 8'hE6});
      chk("bp_shift_ready", {31'd0, r1r}, 0);
      n = 0;
      while (!rv && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("bp_second", {22'd0, rid, rc, rs}, {22'd0, 2'b10, 8'h11});

      // Asynchronous reset after three SHIFT edges.
      @(negedge clk);
      @(negedge clk);
      r0v = 1; r0a = 8'h33; r0b = 8'h44;
      @(negedge clk);
      r0v = 0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 0;
      r0v = 1;
      #1;
      chk("mid_rst_valid", {31'd0, rv}, 0);
      chk("mid_rst_outs", {22'd0, rid, rc, rs}, 0);
      chk("mid_rst_ready", {31'd0, r0r}, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1;
      r0v = 0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (rv) n++;
      end
      chk("mid_rst_noresult", n, 0);

      op8(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, "post_rst");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
